// File: rtl/eq_pkg.sv
// Shared types and helpers for the 16-tap equalizer and its LMS coefficient engine.
package eq_pkg;

   localparam int NTAPS = 16;
   localparam int DW    = 16;

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [DW-1:0] coef_t;
   typedef coef_t coef_arr_t [NTAPS];

   typedef enum logic [1:0] {IDLE, UPD, COMMIT} lms_state_t;

   localparam coef_t COEF_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam coef_t COEF_MIN = {1'b1, {(DW-1){1'b0}}};

   // Clamp a wide signed value into the Q1.15 range.
   function automatic coef_t sat16(input logic signed [2*DW-1:0] v);
      if (v > (2*DW)'(COEF_MAX))
         return COEF_MAX;
      else if (v < (2*DW)'(COEF_MIN))
         return COEF_MIN;
      else
         return coef_t'(v[DW-1:0]);
   endfunction

endpackage

// File: rtl/lms_coef_update_mac.sv
// Single-tap LMS update w + step, saturated; time-shared across all taps.
// LMS_SIGN_SIGN_EN selects the multiplier-free sign-sign step.
module lms_tap_mac
   import eq_pkg::*;
#(
`ifdef LMS_SIGN_SIGN_EN
   parameter int SS_STEP  = 16
`else
   parameter int MU_SHIFT = 4
`endif
) (
   input  sample_t err,
   input  sample_t x,
   input  coef_t   w,
   output coef_t   w_nxt
);

   logic signed [2*DW-1:0] step;
   logic signed [2*DW-1:0] w_sum;

`ifdef LMS_SIGN_SIGN_EN
   always_comb begin
      step = '0;
      if (err != '0 && x != '0)
         step = (err[DW-1] ^ x[DW-1]) ? -(2*DW)'(SS_STEP) : (2*DW)'(SS_STEP);
   end
`else
   logic signed [2*DW-1:0] prod;

   // Q1.15 * Q1.15 leaves 15 extra fraction bits; mu folds into the same floor shift.
   assign prod = (2*DW)'(err) * (2*DW)'(x);
   assign step = prod >>> (15 + MU_SHIFT);
`endif

   assign w_sum = (2*DW)'(w) + step;
   assign w_nxt = sat16(w_sum);

endmodule

// File: rtl/lms_coef_update.sv
// LMS coefficient engine: serial per-tap update into a shadow bank, atomic commit to coef.
// Optional build macro LMS_SIGN_SIGN_EN selects sign-sign adaptation.
module lms_coef_update
   import eq_pkg::*;
#(
`ifdef LMS_SIGN_SIGN_EN
   parameter int    SS_STEP     = 16,
`else
   parameter int    MU_SHIFT    = 4,
`endif
   parameter int    CENTER_TAP  = 7,
   parameter coef_t INIT_CENTER = 16'sh7FFF
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      smp_valid,
   output logic      smp_ready,
   input  sample_t   xn,
   input  sample_t   dn,
   input  sample_t   yn,
   input  logic      adapt_en,
   input  logic      coef_clr,
   output coef_arr_t coef,
   output logic      coef_upd
);

   localparam int            KW     = $clog2(NTAPS);
   localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

   lms_state_t        state, state_nxt;
   logic [KW-1:0]     k;
   sample_t           err;
   sample_t           x_win [NTAPS];
   coef_arr_t         shadow;
   coef_t             tap_nxt;
   logic signed [DW:0] diff;
   logic              accept;

   function automatic coef_arr_t init_bank();
      coef_arr_t b;
      for (int i = 0; i < NTAPS; i++)
         b[i] = (i == CENTER_TAP) ? INIT_CENTER : '0;
      return b;
   endfunction

   assign smp_ready = (state == IDLE);
   assign accept    = smp_valid & smp_ready;
   assign diff      = (DW+1)'(dn) - (DW+1)'(yn);

   lms_tap_mac #(
`ifdef LMS_SIGN_SIGN_EN
      .SS_STEP  (SS_STEP)
`else
      .MU_SHIFT (MU_SHIFT)
`endif
   ) u_mac (
      .err   (err),
      .x     (x_win[k]),
      .w     (shadow[k]),
      .w_nxt (tap_nxt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && adapt_en) state_nxt = UPD;
         UPD:     if (k == K_LAST) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         err      <= '0;
         x_win    <= '{default: '0};
         shadow   <= init_bank();
         coef     <= init_bank();
         coef_upd <= 1'b0;
      end else if (coef_clr) begin
         // Abort: the half-written shadow is discarded, the sample window is kept.
         state    <= IDLE;
         k        <= '0;
         shadow   <= init_bank();
         coef     <= init_bank();
         coef_upd <= 1'b0;
      end else begin
         state    <= state_nxt;
         coef_upd <= (state == COMMIT);
         if (accept) begin
            x_win[0] <= xn;
            for (int i = NTAPS - 1; i > 0; i--)
               x_win[i] <= x_win[i-1];
            err <= sat16((2*DW)'(diff));
         end
         if (state == UPD) begin
            shadow[k] <= tap_nxt;
            k         <= (k == K_LAST) ? '0 : k + KW'(1);
         end
         if (state == COMMIT)
            coef <= shadow;
      end
   end

endmodule

// File: tb/tb_lms_coef_update.sv
// Self-checking bench for lms_coef_update against an arithmetic LMS reference model.
// Honours LMS_SIGN_SIGN_EN when the build defines it.
module tb_lms_coef_update;
   import eq_pkg::*;

   logic      clk = 1'b0;
   logic      rst, smp_valid, adapt_en, coef_clr;
   logic      smp_ready, coef_upd;
   sample_t   xn, dn, yn;
   coef_arr_t coef;

   int n_run  = 0;
   int n_fail = 0;

   int m_x    [NTAPS];
   int m_w    [NTAPS];
   int m_prev [NTAPS];

   lms_coef_update dut (
      .clk       (clk),
      .rst       (rst),
      .smp_valid (smp_valid),
      .smp_ready (smp_ready),
      .xn        (xn),
      .dn        (dn),
      .yn        (yn),
      .adapt_en  (adapt_en),
      .coef_clr  (coef_clr),
      .coef      (coef),
      .coef_upd  (coef_upd)
   );

   always #5 clk = ~clk;

   function automatic int msat(int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int m_step(int e, int x);
`ifdef LMS_SIGN_SIGN_EN
      if (e == 0 || x == 0) return 0;
      return ((e < 0) != (x < 0)) ? -16 : 16;
`else
      return (e * x) >>> 19;
`endif
   endfunction

   function automatic void model_init_w();
      for (int i = 0; i < NTAPS; i++) m_w[i] = (i == 7) ? 32767 : 0;
   endfunction

   task automatic reset_dut();
      rst = 1'b1; smp_valid = 1'b0; adapt_en = 1'b0; coef_clr = 1'b0;
      xn = '0; dn = '0; yn = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NTAPS; i++) m_x[i] = 0;
      model_init_w();
   endtask

   // Presents one triple for a single edge (DUT must be idle) and advances the model.
   task automatic accept(int x, int d, int y, bit a);
      int e;
      xn = 16'(x); dn = 16'(d); yn = 16'(y); adapt_en = a; smp_valid = 1'b1;
      @(posedge clk);
      #1 smp_valid = 1'b0;
      m_prev = m_w;
      for (int i = NTAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
      m_x[0] = int'(xn);
      e = msat(int'(dn) - int'(yn));
      if (a)
         for (int i = 0; i < NTAPS; i++) m_w[i] = msat(m_w[i] + m_step(e, m_x[i]));
   endtask

   task automatic wait_commit(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (coef_upd === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      xn = 16'sh1234; dn = 16'sh4321; yn = 16'sh0101;
      reset_dut();
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL reset_coef[%0d] got %h want %h", i, coef[i], 16'(m_w[i]));
         end
      end
      n_run++;
      if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", smp_ready); end
      n_run++;
      if (coef_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %b want 0", coef_upd); end
   endtask

   task automatic test_basic();
      bit   bad = 1'b0;
      coef_t want0;
`ifdef LMS_SIGN_SIGN_EN
      want0 = 16'sh0010;
`else
      want0 = 16'sh0100;
`endif
      reset_dut();
      accept('h4000, 'h2000, 0, 1'b1);
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         if (coef_upd !== 1'b0) bad = 1'b1;
         for (int i = 0; i < NTAPS; i++) if (coef[i] !== 16'(m_prev[i])) bad = 1'b1;
      end
      n_run++;
      if (bad) begin n_fail++; $display("FAIL basic_early coef/coef_upd changed before T+18 (got 1 want 0)"); end
      @(posedge clk); #1;
      n_run++;
      if (coef_upd !== 1'b1) begin n_fail++; $display("FAIL basic_upd got %b want 1", coef_upd); end
      n_run++;
      if (coef[0] !== want0) begin n_fail++; $display("FAIL basic_coef0 got %h want %h", coef[0], want0); end
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL basic_coef[%0d] got %h want %h", i, coef[i], 16'(m_w[i]));
         end
      end
      @(posedge clk); #1;
      n_run++;
      if (coef_upd !== 1'b0) begin n_fail++; $display("FAIL basic_upd_pulse got %b want 0", coef_upd); end
   endtask

   task automatic test_saturation();
      bit seen;
      for (int ph = 0; ph < 2; ph++) begin
         reset_dut();
         accept('h7FFF, 0, 0, 1'b0);
         repeat (7 - ph) accept(0, 0, 0, 1'b0);
         accept(0, 'h7FFF, 'h8000, 1'b1);
         wait_commit(seen);
         n_run++;
         if (!seen) begin n_fail++; $display("FAIL sat%0d_commit got 0 want 1", ph); end
         n_run++;
         if (coef[7] !== 16'sh7FFF) begin n_fail++; $display("FAIL sat%0d_center got %h want 7fff", ph, coef[7]); end
         for (int i = 0; i < NTAPS; i++) begin
            n_run++;
            if (coef[i] !== 16'(m_w[i])) begin
               n_fail++; $display("FAIL sat%0d_coef[%0d] got %h want %h", ph, i, coef[i], 16'(m_w[i]));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      bit bad = 1'b0;
      reset_dut();
      accept('h1000, 'h3000, 'h1000, 1'b1);
      xn = 16'sh7000; dn = 16'sh7000; yn = '0; adapt_en = 1'b1; smp_valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (smp_ready !== 1'b0) bad = 1'b1;
      end
      smp_valid = 1'b0;
      n_run++;
      if (bad) begin n_fail++; $display("FAIL bp_ready got 1 want 0 during update"); end
      wait_commit(seen);
      n_run++;
      if (!seen) begin n_fail++; $display("FAIL bp_commit got 0 want 1"); end
      accept(0, 'h2000, 0, 1'b1);
      wait_commit(seen);
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL bp_coef[%0d] got %h want %h", i, coef[i], 16'(m_w[i]));
         end
      end
   endtask

   task automatic test_bypass();
      bit seen;
      bit bad = 1'b0;
      accept('h5555, 'h1234, 0, 1'b0);
      n_run++;
      if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready got %b want 1", smp_ready); end
      repeat (20) begin
         @(posedge clk); #1;
         if (coef_upd !== 1'b0) bad = 1'b1;
         for (int i = 0; i < NTAPS; i++) if (coef[i] !== 16'(m_w[i])) bad = 1'b1;
      end
      n_run++;
      if (bad) begin n_fail++; $display("FAIL byp_hold coef/coef_upd changed (got 1 want 0)"); end
      accept(0, 'h4000, 0, 1'b1);
      wait_commit(seen);
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL byp_coef[%0d] got %h want %h", i, coef[i], 16'(m_w[i]));
         end
      end
   endtask

   task automatic test_abort(bit use_rst);
      bit seen;
      bit bad = 1'b0;
      reset_dut();
      accept('h1000, 'h0800, 0, 1'b1);
      wait_commit(seen);
      accept('h4000, 'h2000, 0, 1'b1);
      repeat (7) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1; else coef_clr = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; coef_clr = 1'b0;
      model_init_w();
      if (use_rst) for (int i = 0; i < NTAPS; i++) m_x[i] = 0;
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL abort%0d_coef[%0d] got %h want %h", use_rst, i, coef[i], 16'(m_w[i]));
         end
      end
      n_run++;
      if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL abort%0d_ready got %b want 1", use_rst, smp_ready); end
      repeat (25) begin
         if (coef_upd !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      n_run++;
      if (bad) begin n_fail++; $display("FAIL abort%0d_upd got 1 want 0", use_rst); end
      accept('h1000, 'h4000, 0, 1'b1);
      wait_commit(seen);
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_w[i])) begin
            n_fail++; $display("FAIL abort%0d_next[%0d] got %h want %h", use_rst, i, coef[i], 16'(m_w[i]));
         end
      end
   endtask

   task automatic test_zero_err();
      bit seen;
      accept('h6000, 'h1234, 'h1234, 1'b1);
      wait_commit(seen);
      n_run++;
      if (!seen) begin n_fail++; $display("FAIL zero_commit got 0 want 1"); end
      for (int i = 0; i < NTAPS; i++) begin
         n_run++;
         if (coef[i] !== 16'(m_prev[i])) begin
            n_fail++; $display("FAIL zero_coef[%0d] got %h want %h", i, coef[i], 16'(m_prev[i]));
         end
      end
   endtask

   task automatic test_random();
      bit a;
      bit bad;
      reset_dut();
      for (int s = 0; s < 30; s++) begin
         a = 1'($urandom_range(0, 2) != 0);
         accept(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), a);
         if (!a) begin
            n_run++;
            if (smp_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready got %b want 1", s, smp_ready); end
            continue;
         end
         bad = 1'b0;
         repeat (16) begin
            @(posedge clk); #1;
            if (coef_upd !== 1'b0 || smp_ready !== 1'b0) bad = 1'b1;
         end
         n_run++;
         if (bad) begin n_fail++; $display("FAIL rnd%0d_early upd/ready wrong during update (got 1 want 0)", s); end
         @(posedge clk); #1;
         n_run++;
         if (coef_upd !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_upd got %b want 1", s, coef_upd); end
         for (int i = 0; i < NTAPS; i++) begin
            n_run++;
            if (coef[i] !== 16'(m_w[i])) begin
               n_fail++; $display("FAIL rnd%0d_coef[%0d] got %h want %h", s, i, coef[i], 16'(m_w[i]));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_bypass();
      test_zero_err();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
